// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch / load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int STRB_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: bit 0 is fetch, bit 1 is load/store.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output logic [1:0] gnt
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    if (req == 2'b11) gnt = (last_owner == OWN_IF) ? 2'b10 : 2'b01;
    else              gnt = req;
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates fetch and load/store onto one memory port, one transaction in flight.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              ls_req,
  input  logic              ls_wen,
  input  logic [XLEN-1:0]   ls_addr,
  input  logic [STRB_W-1:0] ls_wstrb,
  input  logic [XLEN-1:0]   ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [XLEN-1:0]   ls_rdata,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_addr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              err_spurious
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;

  logic [1:0] pick_gnt;
  logic       rvalid_in;
  logic       rsp_fwd;

  // Requests and responses are squashed while reset is held so nothing is accepted.
  rr_pick2 u_pick (
    .req        ({ls_req, if_req} & {2{~rst_b}}),
    .last_owner (last_owner_q),
    .gnt        (pick_gnt)
  );

  assign rvalid_in = mem_rvalid & ~rst_b;

  always_comb begin
    // NOTE: every _d takes its held value first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    rsp_fwd      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_gnt != 2'b00) begin
          state_d      = REQ;
          owner_d      = pick_gnt[1] ? OWN_LS : OWN_IF;
          last_owner_d = owner_d;
          if (pick_gnt[1]) begin
            addr_d  = ls_addr;
            wen_d   = ls_wen;
            wstrb_d = ls_wstrb;
            wdata_d = ls_wdata;
          end else begin
            addr_d  = if_addr;
            wen_d   = 1'b0;
            wstrb_d = '0;
            wdata_d = '0;
          end
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = rvalid_in ? IDLE : WAIT;
          rsp_fwd = rvalid_in;
        end
      end
      WAIT: begin
        if (rvalid_in) begin
          state_d = IDLE;
          rsp_fwd = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clearing on completion keeps the memory bus at zero whenever idle.
    if (rsp_fwd) begin
      addr_d  = '0;
      wen_d   = 1'b0;
      wstrb_d = '0;
      wdata_d = '0;
    end

    err_d = err_q | (rvalid_in & ~rsp_fwd);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_LS;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
    end
  end

  assign if_gnt       = (state_q == IDLE) & pick_gnt[0];
  assign ls_gnt       = (state_q == IDLE) & pick_gnt[1];
  assign mem_req      = (state_q == REQ);
  assign mem_wen      = wen_q;
  assign mem_addr     = addr_q;
  assign mem_wstrb    = wstrb_q;
  assign mem_wdata    = wdata_q;
  assign err_spurious = err_q;

  assign if_rvalid = rsp_fwd & (owner_q == OWN_IF);
  assign ls_rvalid = rsp_fwd & (owner_q == OWN_LS);
  assign if_rdata  = (state_q != IDLE && owner_q == OWN_IF) ? mem_rdata : '0;
  assign ls_rdata  = (state_q != IDLE && owner_q == OWN_LS) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed scenarios plus a randomized run against a transaction-level model of the arbiter.
module tb_mem_arb;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_gnt, if_rvalid;
  logic [XLEN-1:0] if_rdata;
  logic            ls_req, ls_wen;
  logic [XLEN-1:0] ls_addr, ls_wdata;
  logic [3:0]      ls_wstrb;
  logic            ls_gnt, ls_rvalid;
  logic [XLEN-1:0] ls_rdata;
  logic            mem_req, mem_wen;
  logic [XLEN-1:0] mem_addr, mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_gnt, mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            err_spurious;

  int n_checks = 0;
  int n_pass   = 0;

  // Transaction-level model: is a transaction open, has memory taken it, who owns it.
  logic            m_busy = 1'b0, m_acc = 1'b0, m_own_ls = 1'b0;
  logic            m_last_ls = 1'b1, m_err = 1'b0;
  logic [XLEN-1:0] m_addr = '0, m_wdata = '0;
  logic            m_wen = 1'b0;
  logic [3:0]      m_wstrb = '0;
  logic            e_if_gnt = 1'b0, e_ls_gnt = 1'b0, e_fwd = 1'b0;

  mem_arb #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .ls_req       (ls_req),
    .ls_wen       (ls_wen),
    .ls_addr      (ls_addr),
    .ls_wstrb     (ls_wstrb),
    .ls_wdata     (ls_wdata),
    .ls_gnt       (ls_gnt),
    .ls_rvalid    (ls_rvalid),
    .ls_rdata     (ls_rdata),
    .mem_req      (mem_req),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_wen = 1'b0; ls_addr = '0; ls_wstrb = '0; ls_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  // Compare every output against the model, mid-cycle after inputs have settled.
  task automatic sample();
    #3;
    e_if_gnt = !rst_b && !m_busy && if_req && (!ls_req || m_last_ls);
    e_ls_gnt = !rst_b && !m_busy && ls_req && (!if_req || !m_last_ls);
    e_fwd    = !rst_b && m_busy && mem_rvalid && (m_acc || mem_gnt);
    check("if_gnt", if_gnt, e_if_gnt);
    check("ls_gnt", ls_gnt, e_ls_gnt);
    check("mem_req", mem_req, m_busy && !m_acc);
    if (!m_busy || !m_acc) begin
      check("mem_addr", mem_addr, m_busy ? m_addr : '0);
      check("mem_wen", mem_wen, m_busy ? m_wen : 1'b0);
      check("mem_wstrb", mem_wstrb, m_busy ? m_wstrb : 4'h0);
      check("mem_wdata", mem_wdata, m_busy ? m_wdata : '0);
    end
    check("if_rvalid", if_rvalid, e_fwd && !m_own_ls);
    check("ls_rvalid", ls_rvalid, e_fwd && m_own_ls);
    if (e_fwd && !m_own_ls) check("if_rdata", if_rdata, mem_rdata);
    if (e_fwd && m_own_ls)  check("ls_rdata", ls_rdata, mem_rdata);
    if (m_busy && m_own_ls)  check("if_rdata_zero", if_rdata, '0);
    if (m_busy && !m_own_ls) check("ls_rdata_zero", ls_rdata, '0);
    check("err_spurious", err_spurious, m_err);
  endtask

  // Advance the model across the rising edge using the inputs of this cycle.
  task automatic tick();
    @(posedge clk);
    if (rst_b) begin
      m_busy = 1'b0; m_acc = 1'b0; m_last_ls = 1'b1; m_err = 1'b0;
      e_if_gnt = 1'b0; e_ls_gnt = 1'b0;
    end else begin
      if (mem_rvalid && !e_fwd) m_err = 1'b1;
      if (e_if_gnt || e_ls_gnt) begin
        m_busy = 1'b1; m_acc = 1'b0; m_own_ls = e_ls_gnt; m_last_ls = e_ls_gnt;
        m_addr  = e_ls_gnt ? ls_addr : if_addr;
        m_wen   = e_ls_gnt ? ls_wen : 1'b0;
        m_wstrb = e_ls_gnt ? ls_wstrb : 4'h0;
        m_wdata = e_ls_gnt ? ls_wdata : '0;
      end else if (e_fwd) begin
        m_busy = 1'b0;
      end else if (m_busy && mem_gnt) begin
        m_acc = 1'b1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    quiet();
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
  endtask

  initial begin
    quiet();
    rst_b = 1'b1;
    do_reset();

    // Reset state.
    sample();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_err", err_spurious, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    tick();

    // Single fetch: grant, address on bus, response routed to fetch only.
    if_req = 1'b1; if_addr = 32'h8000_0000;
    sample(); check("f_gnt", if_gnt, 1'b1); tick();
    if_req = 1'b0; mem_gnt = 1'b1;
    sample(); check("f_mem_req", mem_req, 1'b1); check("f_mem_addr", mem_addr, 32'h8000_0000); tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0413;
    sample();
    check("f_rvalid", if_rvalid, 1'b1);
    check("f_rdata", if_rdata, 32'h0000_0413);
    check("f_ls_rvalid", ls_rvalid, 1'b0);
    tick();
    quiet(); sample(); tick();

    // Both requesting continuously: fetch first, then strict alternation.
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_1000;
    ls_req = 1'b1; ls_addr = 32'h0000_2000;
    for (int c = 0; c < 12; c++) begin
      mem_gnt    = (c % 3 == 1);
      mem_rvalid = (c % 3 == 2);
      mem_rdata  = 32'hA000_0000 + c;
      sample();
      check("alt_if_gnt", if_gnt, (c % 3 == 0) && ((c / 3) % 2 == 0));
      check("alt_ls_gnt", ls_gnt, (c % 3 == 0) && ((c / 3) % 2 == 1));
      tick();
    end

    // Write with memory grant held off three cycles: bus stable, ack to load/store.
    do_reset();
    ls_req = 1'b1; ls_wen = 1'b1; ls_addr = 32'h8000_1004; ls_wstrb = 4'h3; ls_wdata = 32'hDEAD_BEEF;
    sample(); check("w_gnt", ls_gnt, 1'b1); tick();
    quiet();
    for (int c = 0; c < 4; c++) begin
      mem_gnt = (c == 3);
      sample();
      check("w_mem_req", mem_req, 1'b1);
      check("w_mem_addr", mem_addr, 32'h8000_1004);
      check("w_mem_wen", mem_wen, 1'b1);
      check("w_mem_wstrb", mem_wstrb, 4'h3);
      check("w_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    sample(); check("w_ack", ls_rvalid, 1'b1); check("w_if_rvalid", if_rvalid, 1'b0); tick();

    // Grant and response together: pending load/store granted the very next cycle.
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0040;
    sample(); tick();
    if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h0000_0080;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    sample(); check("s_if_rvalid", if_rvalid, 1'b1); check("s_ls_gnt_early", ls_gnt, 1'b0); tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    sample(); check("s_ls_gnt", ls_gnt, 1'b1); tick();
    ls_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
    sample(); check("s_ls_rvalid", ls_rvalid, 1'b1); tick();

    // Spurious response while idle sets a sticky flag cleared only by reset.
    quiet(); mem_rvalid = 1'b1;
    sample(); check("sp_no_fwd", if_rvalid | ls_rvalid, 1'b0); tick();
    mem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample(); check("sp_sticky", err_spurious, 1'b1); tick();
    end
    do_reset();
    sample(); check("sp_cleared", err_spurious, 1'b0); tick();

    // Reset while waiting for a response abandons the transaction.
    if_req = 1'b1; if_addr = 32'h0000_0100;
    sample(); tick();
    if_req = 1'b0; mem_gnt = 1'b1;
    sample(); tick();
    mem_gnt = 1'b0; rst_b = 1'b1;
    sample(); tick();
    rst_b = 1'b0; mem_rvalid = 1'b1;
    sample(); check("ab_mem_req", mem_req, 1'b0); check("ab_fwd", if_rvalid, 1'b0); tick();
    mem_rvalid = 1'b0;
    sample(); check("ab_err", err_spurious, 1'b1); tick();

    // Randomized traffic with occasional resets and stray responses.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (e_if_gnt) if_req = 1'b0;
      if (e_ls_gnt) ls_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!ls_req && $urandom_range(0, 2) == 0) begin
        ls_req = 1'b1; ls_wen = 1'($urandom_range(0, 1)); ls_addr = $urandom;
        ls_wstrb = 4'($urandom_range(0, 15)); ls_wdata = $urandom;
      end
      rst_b = ($urandom_range(0, 299) == 0);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (!rst_b) begin
        if (m_busy && !m_acc) begin
          mem_gnt = 1'($urandom_range(0, 1));
          mem_rvalid = ($urandom_range(0, 2) == 0);
        end else if (m_busy) begin
          mem_rvalid = 1'($urandom_range(0, 1));
        end else begin
          mem_rvalid = ($urandom_range(0, 149) == 0);
        end
      end
      sample();
      tick();
    end
    rst_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_b  input  1  reset; synchronous, active-high.
REQ-004 if_req  input  1  instruction-fetch read request; held until if_gnt.
REQ-005 if_addr  input  XLEN  fetch address.
REQ-006 if_gnt  output  1  one-cycle pulse; fetch request accepted.
REQ-007 if_rvalid  output  1  fetch response valid.
REQ-008 if_rdata  output  XLEN  fetch read data.
REQ-009 ls_req  input  1  load/store request; held with all attributes until ls_gnt.
REQ-010 ls_wen  input  1  1 = write, 0 = read.
REQ-011 ls_addr  input  XLEN  load/store address.
REQ-012 ls_wstrb  input  4  byte write strobe.
REQ-013 ls_wdata  input  XLEN  write data.
REQ-014 ls_gnt  output  1  one-cycle pulse; load/store request accepted.
REQ-015 ls_rvalid  output  1  load/store response valid; also acks writes.
REQ-016 ls_rdata  output  XLEN  load read data.
REQ-017 mem_req, mem_wen, mem_addr, mem_wstrb, mem_wdata  output  1/1/XLEN/4/XLEN  shared memory request bus.
REQ-018 mem_gnt  input  1  memory accepts request.
REQ-019 mem_rvalid, mem_rdata  input  1/XLEN  memory response; one response per accepted request, reads and writes.
REQ-020 err_spurious  output  1  sticky flag, mem_rvalid seen with no transaction outstanding.

Function
REQ-021 FSM states IDLE, REQ, WAIT; exactly one transaction outstanding at any time.
REQ-022 IDLE: any request present -> latch winner's addr/wen/wstrb/wdata and owner, pulse winner's gnt the same cycle, go to REQ.
- Fetch latches wen=0, wstrb=0, wdata=0.
REQ-023 Arbitration is round-robin.
- Only one requester -> it wins.
- Both requesting -> the one not equal to last_owner wins.
- last_owner updates on every grant.
REQ-024 REQ: mem_req=1 with latched attributes, held stable until mem_gnt.
- mem_gnt without mem_rvalid -> WAIT.
- mem_gnt with mem_rvalid in the same cycle -> IDLE.
REQ-025 WAIT: mem_req=0; mem_rvalid -> IDLE.
REQ-026 Response routing is combinational: owner's rvalid = mem_rvalid in REQ (with mem_gnt) or WAIT; owner's rdata = mem_rdata; non-owner rvalid = 0, rdata = 0.
REQ-027 Latency: gnt in cycle N; mem_req first high in N+1; requester response in the cycle mem_rvalid arrives; next grant no earlier than the cycle after the response.
REQ-028 mem_rvalid in IDLE, or in REQ without mem_gnt, sets err_spurious and is not forwarded.
REQ-029 Requests seen in REQ/WAIT are not granted; no gnt pulses outside IDLE.
REQ-030 Outputs in IDLE: mem_req=0, mem_* attributes=0.

Reset
REQ-031 rst_b=1 at a clock edge:
- state=IDLE, last_owner=LS (fetch wins the first contest).
- Latched attributes=0, err_spurious=0.
- All gnt/rvalid/mem_req low.
REQ-032 Reset mid-transaction abandons it; any later mem_rvalid for it sets err_spurious.

Structure
REQ-033 Package mem_arb_pkg holds the state enum (IDLE/REQ/WAIT) and owner enum (OWN_IF/OWN_LS).
REQ-034 One sub-module, rr_pick2: 2-way round-robin picker (req[1:0], last_owner -> grant one-hot); the rest stays flat.

Verification
REQ-035 if_req only, addr 0x80000000, mem_gnt 1 cycle later, mem_rvalid 2 cycles later with 0x00000413 -> if_gnt pulse, mem_addr 0x80000000, if_rvalid with 0x00000413, ls_rvalid stays 0.
REQ-036 if_req and ls_req simultaneously after reset -> fetch granted first, LS granted in the cycle after fetch response; repeat -> strict alternation.
REQ-037 LS write addr 0x80001004, wstrb 0x3, wdata 0xDEADBEEF, mem_gnt delayed 3 cycles -> mem_* stable for 4 cycles, ls_rvalid on ack.
REQ-038 mem_gnt and mem_rvalid in the same cycle -> response forwarded, FSM IDLE next cycle, a pending request granted that cycle.
REQ-039 mem_rvalid while IDLE -> err_spurious=1 and held; rst_b -> cleared.
REQ-040 rst_b asserted in WAIT -> IDLE next cycle, mem_req=0; a later mem_rvalid sets err_spurious.
